coin_acceptor: RTL and testbench
================================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable samples required before a debounced level changes (legal 1..15).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning number of queued coin events (legal 2..8, power of two).
REQ-003 clock  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; asserted (0) clears all state immediately, deasserted (1) synchronously with respect to clock.
REQ-005 coin_n_raw, coin_d_raw, coin_q_raw  in  1 each  raw nickel/dime/quarter sensor levels, asynchronous to clock, active-high, may bounce.
REQ-006 hold  in  1  downstream busy; while 1, no event is issued.
REQ-007 N, D, Q  out  1 each  registered single-cycle coin pulses that feed the vending FSM's N/D/Q inputs directly.
REQ-008 pending  out  4  number of events currently queued (0..FIFO_DEPTH).
REQ-009 overflow  out  1  sticky flag: at least one coin event was dropped since reset.

Function
REQ-010 Each raw input shall pass through a private 2-flop synchronizer; no other logic shall sample a raw input.
REQ-011 Each channel shall hold a debounced level and a counter; counter increments on every edge where synchronized level differs from debounced level, clears on any edge where they match.
REQ-012 When the counter reaches DEBOUNCE_CYCLES, the debounced level shall toggle and the counter clear on that same edge.
REQ-013 A pulse on the synchronized level shorter than DEBOUNCE_CYCLES edges shall produce no change and no event.
REQ-014 Only a 0->1 transition of a debounced level shall generate a coin event; 1->0 transitions generate nothing.
REQ-015 Events shall be registered one edge after the debounced rise and written into the FIFO on the following edge, encoded 2'b01 nickel, 2'b10 dime, 2'b11 quarter.
REQ-016 Events from multiple channels on the same edge shall be written in order nickel, dime, quarter, each consuming one slot.
REQ-017 Free-space check shall include a read occurring on the same edge (full FIFO with simultaneous read accepts one write).
REQ-018 An event with no free slot shall be dropped and overflow set to 1; earlier queued events are unaffected; overflow stays 1 until reset.
REQ-019 On each edge where hold is 0 and FIFO is non-empty, head entry shall be popped and exactly one of N/D/Q registered high for one cycle; otherwise N=D=Q=0.
REQ-020 At most one of N, D, Q shall be high in any cycle; back-to-back pops produce pulses on consecutive cycles.
REQ-021 hold asserted shall freeze the FIFO head; events keep being enqueued.
REQ-022 Latency, empty FIFO and hold=0: raw rise stable from before edge 1 -> output pulse high in cycle after edge DEBOUNCE_CYCLES+4 (edge 8 with default).
REQ-023 pending shall update on the same edge as the write/read that changes it; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-024 While reset=0: N=D=Q=0, pending=0, overflow=0, FIFO empty, synchronizers, debounced levels and counters all 0.
REQ-025 Reset mid-operation shall discard queued and in-flight events with no partial pulse.
REQ-026 A raw input held high across reset release shall debounce normally and produce exactly one event.

Verification
REQ-027 Reset then coin_d_raw 0->1 held 10 cycles, hold=0 -> D high exactly one cycle after edge 8, N=Q=0, pending returns to 0.
REQ-028 coin_n_raw high for 3 cycles, then low (DEBOUNCE_CYCLES=4) -> no N pulse, pending stays 0.
REQ-029 All three raw inputs rise on same cycle -> pulses N, D, Q on three consecutive cycles in that order, pending peaks at 3.
REQ-030 hold=1, five quarter insertions (each separated by 20 idle cycles) -> pending=4, overflow=1; release hold -> exactly four Q pulses, overflow stays 1.
REQ-031 Queue two events with hold=1, assert reset for 1 cycle -> outputs 0 immediately, pending=0, no pulses after release.
REQ-032 Bounce pattern 1,0,1,1,0,1,1,1,1,1... on coin_q_raw -> exactly one Q pulse.

Source files
------------

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces three coin sensors and queues coin events as single-cycle N/D/Q pulses
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coin_n_raw,
    input  logic       coin_d_raw,
    input  logic       coin_q_raw,
    input  logic       hold,
    output logic       N,
    output logic       D,
    output logic       Q,
    output logic [3:0] pending,
    output logic       overflow
);
    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] DEPTH   = 4'(FIFO_DEPTH);

    logic [2:0]    raw, sync1, sync2, deb, event_r;
    logic [3:0]    cnt [3];
    logic [1:0]    fifo [FIFO_DEPTH];
    logic [1:0]    fifo_next [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [3:0]    space, n_wr;
    logic [1:0]    head;
    logic          pop, drop;

    // bit 0 nickel, bit 1 dime, bit 2 quarter; the index+1 is the queued code
    assign raw  = {coin_q_raw, coin_d_raw, coin_n_raw};
    assign head = fifo[rd_ptr];

    // synchronize, debounce, and flag a coin event on the edge the debounced level rises
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            event_r <= '0;
            cnt     <= '{default: '0};
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int c = 0; c < 3; c++) begin
                event_r[c] <= 1'b0;
                if (sync2[c] == deb[c]) begin
                    cnt[c] <= '0;
                end else if (cnt[c] == DB_LAST) begin
                    cnt[c]     <= '0;
                    deb[c]     <= ~deb[c];
                    event_r[c] <= ~deb[c];
                end else begin
                    cnt[c] <= cnt[c] + 4'd1;
                end
            end
        end
    end

    // pop decision and in-order slot allocation; a slot freed by this edge's pop is reusable
    always_comb begin
        pop       = !hold && pending != 4'd0;
        space     = DEPTH - pending + {3'b0, pop};
        n_wr      = '0;
        drop      = 1'b0;
        fifo_next = fifo;
        for (int i = 0; i < 3; i++) begin
            if (event_r[i]) begin
                if (n_wr < space) begin
                    fifo_next[wr_ptr + PW'(n_wr)] = 2'(i + 1);
                    n_wr = n_wr + 4'd1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    // queue state, sticky overflow and registered output pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifo     <= '{default: '0};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            N        <= 1'b0;
            D        <= 1'b0;
            Q        <= 1'b0;
        end else begin
            fifo     <= fifo_next;
            rd_ptr   <= rd_ptr + PW'(pop);
            wr_ptr   <= wr_ptr + PW'(n_wr);
            pending  <= pending + n_wr - {3'b0, pop};
            overflow <= overflow | drop;
            N        <= pop && head == 2'b01;
            D        <= pop && head == 2'b10;
            Q        <= pop && head == 2'b11;
        end
    end
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed vector table plus hand-written corner sequences for coin_acceptor
module tb_coin_acceptor;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       coin_n_raw = 1'b0, coin_d_raw = 1'b0, coin_q_raw = 1'b0;
    logic       hold = 1'b0;
    logic       N, D, Q;
    logic [3:0] pending;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cn, cd, cq, first, last_q, multi;

    coin_acceptor dut (
        .clock(clock), .reset(reset),
        .coin_n_raw(coin_n_raw), .coin_d_raw(coin_d_raw), .coin_q_raw(coin_q_raw),
        .hold(hold), .N(N), .D(D), .Q(Q), .pending(pending), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] raw;
        int         hi;
        logic       hold_v;
        int         exp_n, exp_d, exp_q, exp_first, exp_pend, exp_ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_raw(input logic [2:0] r);
        {coin_q_raw, coin_d_raw, coin_n_raw} = r;
    endtask

    task automatic do_reset;
        set_raw(3'b000);
        hold  = 1'b0;
        reset = 1'b0;
        tick;
        tick;
        reset = 1'b1;
    endtask

    // advance n edges, dropping the raw inputs after edge drop_at, tallying pulses
    task automatic watch(input int n, input int drop_at);
        cn = 0; cd = 0; cq = 0; first = 0; last_q = 0; multi = 0;
        for (int k = 1; k <= n; k++) begin
            tick;
            if (k == drop_at) set_raw(3'b000);
            cn += int'(N);
            cd += int'(D);
            cq += int'(Q);
            if (Q) last_q = k;
            if ((N || D || Q) && first == 0) first = k;
            if (int'(N) + int'(D) + int'(Q) > 1) multi++;
        end
    endtask

    initial begin
        logic bounce [10];
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[0] = '{3'b010, 10, 1'b0, 0, 1, 0, 8, 0, 0};
        vecs[1] = '{3'b001,  3, 1'b0, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{3'b001,  4, 1'b0, 1, 0, 0, 8, 0, 0};
        vecs[3] = '{3'b111, 10, 1'b0, 1, 1, 1, 8, 0, 0};
        vecs[4] = '{3'b100, 10, 1'b1, 0, 0, 0, 0, 1, 0};
        vecs[5] = '{3'b101, 10, 1'b1, 0, 0, 0, 0, 2, 0};
        vecs[6] = '{3'b110, 10, 1'b0, 0, 1, 1, 8, 0, 0};
        vecs[7] = '{3'b111,  2, 1'b0, 0, 0, 0, 0, 0, 0};

        tick;
        chk("rst_ndq", int'({N, D, Q}), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_overflow", int'(overflow), 0);

        for (int i = 0; i < 8; i++) begin
            do_reset;
            hold = vecs[i].hold_v;
            set_raw(vecs[i].raw);
            watch(30, vecs[i].hi);
            chk($sformatf("v%0d_n", i), cn, vecs[i].exp_n);
            chk($sformatf("v%0d_d", i), cd, vecs[i].exp_d);
            chk($sformatf("v%0d_q", i), cq, vecs[i].exp_q);
            chk($sformatf("v%0d_first", i), first, vecs[i].exp_first);
            chk($sformatf("v%0d_pending", i), int'(pending), vecs[i].exp_pend);
            chk($sformatf("v%0d_overflow", i), int'(overflow), vecs[i].exp_ovf);
            chk($sformatf("v%0d_onehot", i), multi, 0);
        end

        do_reset;
        set_raw(3'b111);
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (k == 10) set_raw(3'b000);
            if (k == 7)  chk("order_peak", int'(pending), 3);
            if (k == 8)  chk("order_n", int'({N, D, Q}), 4);
            if (k == 9)  chk("order_d", int'({N, D, Q}), 2);
            if (k == 10) chk("order_q", int'({N, D, Q}), 1);
            if (k == 11) chk("order_empty", int'(pending), 0);
        end

        do_reset;
        hold = 1'b1;
        for (int j = 0; j < 5; j++) begin
            set_raw(3'b100);
            watch(30, 10);
        end
        chk("ovf_pending", int'(pending), 4);
        chk("ovf_flag", int'(overflow), 1);
        hold = 1'b0;
        watch(10, 0);
        chk("ovf_q_pulses", cq, 4);
        chk("ovf_q_back2back", last_q - first, 3);
        chk("ovf_sticky", int'(overflow), 1);
        chk("ovf_drained", int'(pending), 0);

        do_reset;
        hold = 1'b1;
        for (int j = 0; j < 4; j++) begin
            set_raw(3'b100);
            watch(30, 10);
        end
        chk("full_pending", int'(pending), 4);
        set_raw(3'b001);
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (k == 6)  hold = 1'b0;
            if (k == 10) set_raw(3'b000);
            if (k == 7) begin
                chk("full_rw_pending", int'(pending), 4);
                chk("full_rw_overflow", int'(overflow), 0);
                chk("full_rw_q0", int'({N, D, Q}), 1);
            end
            if (k >= 8 && k <= 10) chk($sformatf("full_rw_q%0d", k - 7), int'({N, D, Q}), 1);
            if (k == 11) chk("full_rw_n", int'({N, D, Q}), 4);
            if (k == 12) chk("full_rw_empty", int'(pending), 0);
        end

        do_reset;
        hold = 1'b1;
        set_raw(3'b011);
        watch(20, 10);
        chk("midrst_queued", int'(pending), 2);
        #2 reset = 1'b0;
        #1;
        chk("midrst_ndq", int'({N, D, Q}), 0);
        chk("midrst_pending", int'(pending), 0);
        tick;
        reset = 1'b1;
        hold  = 1'b0;
        watch(30, 0);
        chk("midrst_no_pulses", cn + cd + cq, 0);

        set_raw(3'b010);
        reset = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        watch(30, 15);
        chk("held_across_rst_d", cd, 1);
        chk("held_across_rst_nq", cn + cq, 0);

        do_reset;
        cq = 0;
        for (int k = 0; k < 10; k++) begin
            coin_q_raw = bounce[k];
            tick;
            cq += int'(Q);
        end
        begin
            int pre = cq;
            watch(40, 10);
            chk("bounce_q", pre + cq, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
